// File: rtl/route_sched.sv
// Multi-stop route scheduler: queues destination IDs from the UART and issues
// them one at a time as GO commands, dwelling at each station in between.
module route_sched #(
  parameter int DEPTH = 4,
  parameter int DWELL = 1000,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       uart_cmd,
  input  logic             uart_rdy,
  output logic             clr_uart_rdy,
  output logic [7:0]       cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             in_transit,
  output logic [CNT_W-1:0] q_cnt,
  output logic             q_full,
  output logic             q_empty,
  output logic             dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_GO     = 2'b01;
  localparam logic [1:0] OP_APPEND = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_ST = 3'd2,
    S_TRANSIT = 3'd3,
    S_DWELL   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic               cmd_rdy_q, cmd_rdy_d;
  logic               stop_pend_q, stop_pend_d;
  logic               preempt_q, preempt_d;
  logic [DW_W-1:0]    dwell_cnt_q, dwell_cnt_d;
  logic [5:0]         mem_q [DEPTH];
  logic [5:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dropped_q, dropped_d;

  logic [1:0] op;
  logic [5:0] dest;
  logic [5:0] head;
  logic       op_stop, op_go, op_app, flush;
  logic       ack, cmd_is_stop, pop, push_ok, full_int, empty_int;
  logic       redirect, dwell_done, enter_issue;

  assign op          = uart_cmd[7:6];
  assign dest        = uart_cmd[5:0];
  assign op_stop     = uart_rdy && (op == OP_STOP);
  assign op_go       = uart_rdy && (op == OP_GO);
  assign op_app      = uart_rdy && (op == OP_APPEND);
  assign flush       = op_stop || op_go;
  assign head        = mem_q[rd_ptr_q];
  assign full_int    = (cnt_q == CNT_W'(DEPTH));
  assign empty_int   = (cnt_q == {CNT_W{1'b0}});
  assign ack         = cmd_rdy_q && clr_cmd_rdy;
  assign cmd_is_stop = (cmd_q[7:6] == OP_STOP);
  // Guarding on a non-empty queue keeps a stale GO ack after a flush harmless.
  assign pop         = ack && (state_q == S_ISSUE) && !cmd_is_stop && !empty_int;
  assign push_ok     = op_app && (!full_int || pop);
  assign redirect    = stop_pend_q || preempt_q;
  assign dwell_done  = (dwell_cnt_q == DW_W'(DWELL - 1));
  assign enter_issue = (state_q != S_ISSUE) && (state_d == S_ISSUE);

  assign clr_uart_rdy = uart_rdy;
  assign cmd          = cmd_q;
  assign cmd_rdy      = cmd_rdy_q;
  assign q_cnt        = cnt_q;
  assign q_full       = full_int;
  assign q_empty      = empty_int;
  assign dropped      = dropped_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= 8'h00;
      cmd_rdy_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      preempt_q   <= 1'b0;
      dwell_cnt_q <= {DW_W{1'b0}};
      mem_q       <= '{default: 6'd0};
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      stop_pend_q <= stop_pend_d;
      preempt_q   <= preempt_d;
      dwell_cnt_q <= dwell_cnt_d;
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      dropped_q   <= dropped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (stop_pend_q || !empty_int) state_d = S_ISSUE;
        else                           state_d = S_IDLE;
      end
      S_ISSUE: begin
        if (ack) state_d = cmd_is_stop ? S_IDLE : S_WAIT_ST;
        else     state_d = S_ISSUE;
      end
      S_WAIT_ST: begin
        if (redirect)        state_d = S_ISSUE;
        else if (in_transit) state_d = S_TRANSIT;
        else                 state_d = S_WAIT_ST;
      end
      S_TRANSIT: begin
        if (redirect)         state_d = S_ISSUE;
        else if (!in_transit) state_d = S_DWELL;
        else                  state_d = S_TRANSIT;
      end
      S_DWELL: begin
        if (redirect)        state_d = S_ISSUE;
        else if (dwell_done) state_d = empty_int ? S_IDLE : S_ISSUE;
        else                 state_d = S_DWELL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // While a command is offered, newer STOP/GO bytes rewrite it in place.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    stop_pend_d = stop_pend_q;
    preempt_d   = preempt_q;
    if (enter_issue) begin
      cmd_rdy_d = 1'b1;
      cmd_d     = stop_pend_q ? 8'h00 : {OP_GO, head};
    end else if (state_q == S_ISSUE) begin
      if (ack)                              cmd_rdy_d = 1'b0;
      else if (op_stop)                     cmd_d = 8'h00;
      else if (op_go)                       cmd_d = {OP_GO, dest};
      else if (stop_pend_q && !cmd_is_stop) cmd_d = 8'h00;
      else if (preempt_q)                   cmd_d = {OP_GO, head};
      else                                  cmd_d = cmd_q;
    end else begin
      cmd_d     = cmd_q;
      cmd_rdy_d = cmd_rdy_q;
    end

    if (op_stop)                                          stop_pend_d = 1'b1;
    else if (op_go)                                       stop_pend_d = 1'b0;
    else if ((state_q == S_ISSUE) && ack && cmd_is_stop)  stop_pend_d = 1'b0;
    else                                                  stop_pend_d = stop_pend_q;

    // A GO that lands while its predecessor is being acked must re-issue later.
    if (op_stop)                                          preempt_d = 1'b0;
    else if (op_go)                                       preempt_d = !((state_q == S_ISSUE) && !ack);
    else if (enter_issue || ((state_q == S_ISSUE) && !ack)) preempt_d = 1'b0;
    else                                                  preempt_d = preempt_q;

    if ((state_q == S_DWELL) && (state_d == S_DWELL)) dwell_cnt_d = dwell_cnt_q + DW_W'(1);
    else                                              dwell_cnt_d = {DW_W{1'b0}};
  end

  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    dropped_d = 1'b0;
    if (flush) begin
      rd_ptr_d = {PTR_W{1'b0}};
      if (op_go) begin
        mem_d[0] = dest;
        wr_ptr_d = PTR_W'(1);
        cnt_d    = CNT_W'(1);
      end else begin
        wr_ptr_d = {PTR_W{1'b0}};
        cnt_d    = {CNT_W{1'b0}};
      end
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else     rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
        mem_d[wr_ptr_q] = dest;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (push_ok && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push_ok) cnt_d = cnt_q - CNT_W'(1);
      else                      cnt_d = cnt_q;
      dropped_d = op_app && !push_ok;
    end
  end

endmodule
